hud_hearts_renderer: RTL
========================

Name: hud_hearts_renderer

Overview:
Draws the player's remaining lives as a row of 15x15 heart sprites on the HUD. It sits between the VGA pixel counters and the heart sprite ROM, and acts as the ROM's reader. It drives the ROM's x/y/en address inputs from the current pixel position and registers the returned bit as a HUD pixel. It also owns the lives counter, the damage-blink animation and the game-over flag.

Parameters:
MAX_LIVES, 3, lives restored on reset or restart; 1..7
ORIGIN_X, 8, screen x of the left column of heart slot 0
ORIGIN_Y, 8, screen y of the top row of all heart slots
SPACING, 16, horizontal pitch between slots in pixels; must be >= 15
BLINK_FRAMES, 48, frame ticks a lost heart blinks before vanishing
BLINK_HALF, 8, frame ticks per blink on/off phase

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame (vsync start)
pix_x  in  10  current pixel column
pix_y  in  10  current pixel row
pix_valid  in  1  pixel is in the active area
life_lost  in  1  one-cycle pulse: player hit
life_gain  in  1  one-cycle pulse: extra life
game_restart  in  1  one-cycle pulse: restore lives
sprite_x  out  4  column index into the heart ROM (registered)
sprite_y  out  4  row index into the heart ROM (registered)
sprite_en  out  1  ROM enable (registered)
sprite_data  in  1  ROM bit, combinational from sprite_x/y/en
heart_pixel  out  1  HUD heart pixel on
heart_valid  out  1  pix_valid delayed 2 cycles
lives  out  3  current life count
game_over  out  1  high while in GAME_OVER

Behaviour:
- Reset (rst=1 at a rising edge): lives=MAX_LIVES, FSM=IDLE, blink counters=0, blink_slot=0. All outputs except lives read 0.
- Slot hit test (cycle 0):
  - k = (pix_x-ORIGIN_X)/SPACING; dx = (pix_x-ORIGIN_X)%SPACING; dy = pix_y-ORIGIN_Y.
  - Hit when pix_valid, pix_x>=ORIGIN_X, dx<15, 0<=dy<15 and k<MAX_LIVES.
  - Division must be implemented by a running slot/offset comparison, not a divider.
- Slot visibility: slot k is visible if k<lives, or if FSM=BLINK and k==blink_slot and blink_on=1.
- Pipeline:
  - Cycle 1: sprite_x=dx, sprite_y=dy, sprite_en=hit&visible; zeros otherwise.
  - Cycle 2: heart_pixel=sprite_data&sprite_en_d, heart_valid=pix_valid_d2.
  - Fixed latency is 2 cycles from pix_* to heart_*.
- Lives update, priority restart > (lost,gain):
  - restart: lives=MAX_LIVES, FSM=IDLE.
  - lost only, lives>0: lives-=1, blink_slot=new lives value, FSM=BLINK, blink_cnt=0, blink_on=1.
  - gain only: lives=min(lives+1, MAX_LIVES). Ignored in GAME_OVER.
  - lost and gain together: no change, no blink.
  - lost with lives=0: ignored.
- FSM:
  - IDLE: waits for life_lost.
  - BLINK: on each frame_tick, blink_cnt++ and blink_on toggles every BLINK_HALF ticks. When blink_cnt reaches BLINK_FRAMES, go to GAME_OVER if lives==0, else IDLE.
  - BLINK, new life_lost: restart blink with the new slot.
  - BLINK, life_gain restoring blink_slot: go straight to IDLE.
  - GAME_OVER: game_over=1; only restart or rst leaves it.
- Mid-frame changes to lives take effect on the next pixel; no frame buffering.

Optional Feature:
HUD_HEART_BLINK_EN.
- Defined: BLINK state and counters as above.
- Undefined: no BLINK state or counters. A lost heart disappears on the next cycle, and lives reaching 0 enters GAME_OVER the cycle after life_lost.

Test Plan:
- rst, then scan pixel (8,8)..(22,22) with pix_valid=1 -> sprite_en=1 one cycle later; heart_pixel equals ROM pattern two cycles later; lives=3, game_over=0.
- Pixel (23,8) (dx=15 gap) and (8,23) -> sprite_en=0, heart_pixel=0.
- life_lost with lives=3 -> lives=2. Slot 2 (x=40..54) toggles visibility every 8 frame_ticks. After 48 ticks slot 2 is dark; FSM back to IDLE.
- Three life_lost pulses spaced 50 frames apart -> lives=0; game_over=1 after the final blink. A further life_gain leaves lives=0; game_restart gives lives=3, game_over=0.
- life_lost and life_gain in the same cycle with lives=2 -> lives stays 2, no blink. life_gain at lives=3 -> stays 3.
- rst asserted mid-BLINK -> next cycle lives=3, all slots visible, heart_valid=0.

Source files
------------

// File: rtl/hud_hearts_renderer_if.sv
// Heart sprite ROM read bus: the renderer (master) drives the address/enable,
// and the ROM (slave) returns one combinational pixel bit.
interface hud_hearts_renderer_if;
   logic [3:0] sprite_x;
   logic [3:0] sprite_y;
   logic       sprite_en;
   logic       sprite_data;

   modport master (output sprite_x, output sprite_y, output sprite_en, input sprite_data);
   modport slave  (input sprite_x, input sprite_y, input sprite_en, output sprite_data);
endinterface

// File: rtl/hud_hearts_renderer.sv
// HUD lives display: hit-tests pixels against a row of 15x15 heart slots, reads the
// heart ROM, and owns lives / game-over. Define HUD_HEART_BLINK_EN for the damage blink.
module hud_hearts_renderer #(
   parameter int unsigned MAX_LIVES    = 3,
   parameter int unsigned ORIGIN_X     = 8,
   parameter int unsigned ORIGIN_Y     = 8,
   parameter int unsigned SPACING      = 16,
   parameter int unsigned BLINK_FRAMES = 48,
   parameter int unsigned BLINK_HALF   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_tick,
   input  logic [9:0]            pix_x,
   input  logic [9:0]            pix_y,
   input  logic                  pix_valid,
   input  logic                  life_lost,
   input  logic                  life_gain,
   input  logic                  game_restart,
   hud_hearts_renderer_if.master rom,
   output logic                  heart_pixel,
   output logic                  heart_valid,
   output logic [2:0]            lives,
   output logic                  game_over
);

`ifdef HUD_HEART_BLINK_EN
   localparam int unsigned CW = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned HW = $clog2(BLINK_HALF + 1);
   typedef enum logic [1:0] {S_IDLE, S_BLINK, S_OVER} state_t;
   logic [CW-1:0] blink_cnt;
   logic [HW-1:0] half_cnt;
   logic          blink_on;
   logic [2:0]    blink_slot;
`else
   typedef enum logic [0:0] {S_IDLE, S_OVER} state_t;
`endif

   state_t     state;
   logic [9:0] relx, rely;
   logic [3:0] dx;
   logic [2:0] slot;
   logic       hit, visible, pv_d1;

   // Slot search by comparing against each slot's constant window; no divider needed.
   always_comb begin
      relx = pix_x - 10'(ORIGIN_X);
      rely = pix_y - 10'(ORIGIN_Y);
      hit  = 1'b0;
      dx   = '0;
      slot = '0;
      for (int unsigned k = 0; k < MAX_LIVES; k++) begin
         if (relx >= 10'(k * SPACING) && relx < 10'(k * SPACING + 15)) begin
            hit  = 1'b1;
            dx   = 4'(relx - 10'(k * SPACING));
            slot = 3'(k);
         end
      end
      hit = hit && pix_valid && (pix_x >= 10'(ORIGIN_X)) &&
            (pix_y >= 10'(ORIGIN_Y)) && (rely < 10'd15);
   end

   always_comb begin
      visible = (slot < lives);
`ifdef HUD_HEART_BLINK_EN
      if (state == S_BLINK && slot == blink_slot && blink_on)
         visible = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rom.sprite_x  <= '0;
         rom.sprite_y  <= '0;
         rom.sprite_en <= 1'b0;
         pv_d1         <= 1'b0;
         heart_valid   <= 1'b0;
         heart_pixel   <= 1'b0;
      end else begin
         rom.sprite_x  <= (hit && visible) ? dx : '0;
         rom.sprite_y  <= (hit && visible) ? rely[3:0] : '0;
         rom.sprite_en <= hit && visible;
         pv_d1         <= pix_valid;
         heart_valid   <= pv_d1;
         heart_pixel   <= rom.sprite_data & rom.sprite_en;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || game_restart) begin
         lives      <= 3'(MAX_LIVES);
         state      <= S_IDLE;
         game_over  <= 1'b0;
`ifdef HUD_HEART_BLINK_EN
         blink_cnt  <= '0;
         half_cnt   <= '0;
         blink_on   <= 1'b0;
         blink_slot <= '0;
`endif
      end else if (state != S_OVER) begin
`ifdef HUD_HEART_BLINK_EN
         // Frame-driven blink progress; a same-cycle life event below overrides it.
         if (state == S_BLINK && frame_tick) begin
            if (half_cnt == HW'(BLINK_HALF - 1)) begin
               half_cnt <= '0;
               blink_on <= ~blink_on;
            end else begin
               half_cnt <= half_cnt + 1'b1;
            end
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
               blink_cnt <= '0;
               state     <= (lives == 3'd0) ? S_OVER : S_IDLE;
               game_over <= (lives == 3'd0);
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
`endif
         if (life_lost && !life_gain && lives != 3'd0) begin
            lives <= lives - 3'd1;
`ifdef HUD_HEART_BLINK_EN
            blink_slot <= lives - 3'd1;
            state      <= S_BLINK;
            blink_cnt  <= '0;
            half_cnt   <= '0;
            blink_on   <= 1'b1;
            game_over  <= 1'b0;
`else
            if (lives == 3'd1) begin
               state     <= S_OVER;
               game_over <= 1'b1;
            end
`endif
         end else if (life_gain && !life_lost) begin
            if (lives < 3'(MAX_LIVES))
               lives <= lives + 3'd1;
`ifdef HUD_HEART_BLINK_EN
            if (state == S_BLINK && lives >= blink_slot) begin
               state     <= S_IDLE;
               game_over <= 1'b0;
            end
`endif
         end
      end
   end

endmodule
